// File: rtl/udp_rx_word_pkg.sv
// Shared constants, state encoding and CRC helpers for the GMII UDP/IPv4 receive path.
package udp_rx_word_pkg;

  typedef enum logic [3:0] {
    S_WAIT_IDLE,
    S_IDLE,
    S_PREAMBLE,
    S_ETH_HEAD,
    S_IP_HEAD,
    S_UDP_HEAD,
    S_RX_DATA,
    S_RX_PAD,
    S_DISCARD,
    S_END
  } rx_state_e;

  localparam logic [15:0] ETH_TYPE_IPV4 = 16'h0800;
  localparam logic [7:0]  IP_PROTO_UDP  = 8'd17;
  localparam logic [7:0]  IP_VER_IHL    = 8'h45;
  localparam logic [7:0]  PREAMBLE_BYTE = 8'h55;
  localparam logic [7:0]  SFD_BYTE      = 8'hD5;

  localparam int unsigned PREAMBLE_REPEAT = 6;
  localparam int unsigned ETH_HEAD_LEN    = 14;
  localparam int unsigned IP_HEAD_LEN     = 20;
  localparam int unsigned UDP_HEAD_LEN    = 8;
  localparam int unsigned HDR_CNT_W       = 5;

  localparam logic [31:0] CRC32_POLY = 32'h04C11DB7;

  typedef struct packed {
    logic [47:0] mac;
    logic [31:0] ip;
    logic [15:0] port;
  } peer_t;

  // MSB-first CRC-32 step; GMII bytes go out LSB first, so data[0] is consumed first.
  function automatic logic [31:0] crc32_d8_step(input logic [31:0] crc, input logic [7:0] data);
    logic [31:0] c;
    logic        fb;
    c = crc;
    for (int i = 0; i < 8; i++) begin
      fb = c[31] ^ data[i];
      c  = {c[30:0], 1'b0} ^ (fb ? CRC32_POLY : 32'h0);
    end
    return c;
  endfunction

  // Expected FCS as it sits in the delay line: byte k = ~{c[8k], ..., c[8k+7]}, byte 0 oldest.
  function automatic logic [31:0] fcs_expected(input logic [31:0] c);
    logic [31:0] f;
    f = '0;
    for (int k = 0; k < 4; k++) begin
      for (int j = 0; j < 8; j++) begin
        f[31 - 8*k - j] = ~c[8*k + j];
      end
    end
    return f;
  endfunction

  // Left-align the n newest bytes of w (n = 0 means a full group of four).
  function automatic logic [31:0] left_align(input logic [31:0] w, input logic [1:0] n);
    logic [31:0] r;
    case (n)
      2'd1:    r = {w[7:0], 24'h0};
      2'd2:    r = {w[15:0], 16'h0};
      2'd3:    r = {w[23:0], 8'h0};
      default: r = w;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/udp_rx_word_crc.sv
// Byte-wide CRC-32 engine (crc32_d8); crc_data is published byte-swapped so FCS byte k
// is the bit-reversed complement of crc_data[8k +: 8].
module crc32_d8
  import udp_rx_word_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        crc_en,
  input  logic        crc_clr,
  input  logic [7:0]  data,
  output logic [31:0] crc_data
);

  logic [31:0] crc_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      crc_q <= '1;
    end else if (crc_clr) begin
      crc_q <= '1;
    end else if (crc_en) begin
      crc_q <= crc32_d8_step(crc_q, data);
    end
  end

  assign crc_data = {crc_q[7:0], crc_q[15:8], crc_q[23:16], crc_q[31:24]};

endmodule

// File: rtl/udp_rx_word.sv
// GMII UDP/IPv4 receiver: header parse and filter, payload packed into 32-bit words,
// FCS check, sender MAC/IP/port latched for the reply path.
module udp_rx_word
  import udp_rx_word_pkg::*;
#(
  parameter logic [47:0] BOARD_MAC     = 48'h001122334455,
  parameter logic [31:0] BOARD_IP      = {8'd192, 8'd168, 8'd1, 8'd10},
  parameter logic [15:0] BOARD_PORTNUM = 16'd1010,
  parameter bit          CHECK_CRC     = 1'b1
) (
  input  logic        i_gmii_rx_clk,
  input  logic        i_sys_rstn,
  input  logic        i_gmii_rx_dv,
  input  logic [7:0]  i_gmii_rx_data,
  output logic        o_rec_word_en,
  output logic [31:0] o_rec_word,
  output logic [15:0] o_rec_byte_num,
  output logic        o_rec_pkt_done,
  output logic        o_rec_err,
  output logic [47:0] o_src_mac,
  output logic [31:0] o_src_ip,
  output logic [15:0] o_src_port
);

  localparam logic [47:0] MAC_BCAST = 48'hffff_ffff_ffff;
  localparam logic [HDR_CNT_W-1:0] PRE_LAST  = HDR_CNT_W'(PREAMBLE_REPEAT);
  localparam logic [HDR_CNT_W-1:0] ETH_LAST  = HDR_CNT_W'(ETH_HEAD_LEN - 1);
  localparam logic [HDR_CNT_W-1:0] IP_LAST   = HDR_CNT_W'(IP_HEAD_LEN - 1);
  localparam logic [HDR_CNT_W-1:0] UDP_LAST  = HDR_CNT_W'(UDP_HEAD_LEN - 1);
  localparam logic [15:0]          UDP_HLEN  = 16'(UDP_HEAD_LEN);

  rx_state_e state, state_nxt;

  logic [HDR_CNT_W-1:0] hdr_cnt;
  logic [39:0]          hdr_sr;
  logic [47:0]          hdr_sr_nxt;
  logic [15:0]          data_cnt;
  logic [31:0]          pack, pack_nxt;
  logic [31:0]          dly;
  logic [2:0]           dly_cnt;
  logic                 dv;
  logic [7:0]           rxd;
  logic                 post_sfd, last_byte, fcs_bad;
  logic                 crc_en, crc_clr;
  logic [31:0]          crc_data;
  peer_t                shadow, src_q;

  assign dv         = i_gmii_rx_dv;
  assign rxd        = i_gmii_rx_data;
  assign hdr_sr_nxt = {hdr_sr, rxd};
  assign pack_nxt   = {pack[23:0], rxd};
  assign last_byte  = (16'(data_cnt + 16'd1) == o_rec_byte_num);
  assign post_sfd   = state inside {S_ETH_HEAD, S_IP_HEAD, S_UDP_HEAD, S_RX_DATA, S_RX_PAD};

  // Four-byte delay line keeps the FCS out of the CRC engine.
  assign crc_en  = post_sfd && dv && (dly_cnt == 3'd4);
  assign crc_clr = (state == S_IDLE);
  assign fcs_bad = (dly_cnt != 3'd4) || (dly != fcs_expected(crc_data));

  crc32_d8 u_crc (
    .clk      (i_gmii_rx_clk),
    .rst_n    (i_sys_rstn),
    .crc_en   (crc_en),
    .crc_clr  (crc_clr),
    .data     (dly[31:24]),
    .crc_data (crc_data)
  );

  always_ff @(posedge i_gmii_rx_clk or negedge i_sys_rstn) begin
    if (!i_sys_rstn) begin
      state <= S_WAIT_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state: header walk and filtering.
  always_comb begin
    state_nxt = state;
    case (state)
      S_WAIT_IDLE: if (!dv) state_nxt = S_IDLE;
      S_IDLE: begin
        if (dv) state_nxt = (rxd == PREAMBLE_BYTE) ? S_PREAMBLE : S_DISCARD;
      end
      S_PREAMBLE: begin
        if (!dv) begin
          state_nxt = S_IDLE;
        end else if (rxd == PREAMBLE_BYTE && hdr_cnt < PRE_LAST) begin
          state_nxt = S_PREAMBLE;
        end else if (rxd == SFD_BYTE && hdr_cnt == PRE_LAST) begin
          state_nxt = S_ETH_HEAD;
        end else begin
          state_nxt = S_DISCARD;
        end
      end
      S_ETH_HEAD: begin
        if (!dv) begin
          state_nxt = S_IDLE;
        end else if (hdr_cnt == HDR_CNT_W'(5) &&
                     hdr_sr_nxt != BOARD_MAC && hdr_sr_nxt != MAC_BCAST) begin
          state_nxt = S_DISCARD;
        end else if (hdr_cnt == ETH_LAST) begin
          state_nxt = (hdr_sr_nxt[15:0] == ETH_TYPE_IPV4) ? S_IP_HEAD : S_DISCARD;
        end
      end
      S_IP_HEAD: begin
        if (!dv) begin
          state_nxt = S_IDLE;
        end else if ((hdr_cnt == HDR_CNT_W'(0) && rxd != IP_VER_IHL) ||
                     (hdr_cnt == HDR_CNT_W'(9) && rxd != IP_PROTO_UDP)) begin
          state_nxt = S_DISCARD;
        end else if (hdr_cnt == IP_LAST) begin
          state_nxt = (hdr_sr_nxt[31:0] == BOARD_IP) ? S_UDP_HEAD : S_DISCARD;
        end
      end
      S_UDP_HEAD: begin
        if (!dv) begin
          state_nxt = S_IDLE;
        end else if ((hdr_cnt == HDR_CNT_W'(3) && hdr_sr_nxt[15:0] != BOARD_PORTNUM) ||
                     (hdr_cnt == HDR_CNT_W'(5) && hdr_sr_nxt[15:0] < UDP_HLEN)) begin
          state_nxt = S_DISCARD;
        end else if (hdr_cnt == UDP_LAST) begin
          state_nxt = (hdr_sr_nxt[31:16] == UDP_HLEN) ? S_RX_PAD : S_RX_DATA;
        end
      end
      S_RX_DATA: begin
        if (!dv)            state_nxt = S_END;
        else if (last_byte) state_nxt = S_RX_PAD;
      end
      S_RX_PAD:  if (!dv) state_nxt = S_END;
      S_DISCARD: if (!dv) state_nxt = S_IDLE;
      S_END:     state_nxt = S_IDLE;
      default:   state_nxt = S_WAIT_IDLE;
    endcase
  end

  // Datapath and registered outputs.
  always_ff @(posedge i_gmii_rx_clk or negedge i_sys_rstn) begin
    if (!i_sys_rstn) begin
      hdr_cnt        <= '0;
      hdr_sr         <= '0;
      data_cnt       <= '0;
      pack           <= '0;
      dly            <= '0;
      dly_cnt        <= '0;
      shadow         <= '0;
      src_q          <= '0;
      o_rec_word_en  <= 1'b0;
      o_rec_word     <= '0;
      o_rec_byte_num <= '0;
      o_rec_pkt_done <= 1'b0;
      o_rec_err      <= 1'b0;
    end else begin
      o_rec_word_en  <= 1'b0;
      o_rec_pkt_done <= 1'b0;

      if (state_nxt != state) hdr_cnt <= '0;
      else if (dv)            hdr_cnt <= HDR_CNT_W'(hdr_cnt + HDR_CNT_W'(1));

      if (dv) hdr_sr <= hdr_sr_nxt[39:0];

      if (state == S_IDLE) begin
        dly     <= '0;
        dly_cnt <= '0;
      end else if (post_sfd && dv) begin
        dly <= {dly[23:0], rxd};
        if (dly_cnt != 3'd4) dly_cnt <= 3'(dly_cnt + 3'd1);
      end

      case (state)
        S_ETH_HEAD: begin
          if (dv && hdr_cnt == HDR_CNT_W'(11)) shadow.mac <= hdr_sr_nxt;
        end
        S_IP_HEAD: begin
          if (dv && hdr_cnt == HDR_CNT_W'(15)) shadow.ip <= hdr_sr_nxt[31:0];
        end
        S_UDP_HEAD: begin
          if (dv && hdr_cnt == HDR_CNT_W'(1)) shadow.port <= hdr_sr_nxt[15:0];
          if (dv && hdr_cnt == UDP_LAST) begin
            o_rec_byte_num <= 16'(hdr_sr_nxt[31:16] - UDP_HLEN);
            data_cnt       <= '0;
            pack           <= '0;
          end
        end
        S_RX_DATA: begin
          if (dv) begin
            pack     <= pack_nxt;
            data_cnt <= 16'(data_cnt + 16'd1);
            if (data_cnt[1:0] == 2'd3 || last_byte) begin
              o_rec_word_en <= 1'b1;
              o_rec_word    <= left_align(pack_nxt, 2'(data_cnt[1:0] + 2'd1));
            end
          end else begin
            // Truncated payload: flush what is pending alongside the done strobe.
            if (data_cnt[1:0] != 2'd0) begin
              o_rec_word_en <= 1'b1;
              o_rec_word    <= left_align(pack, data_cnt[1:0]);
            end
            o_rec_pkt_done <= 1'b1;
            o_rec_err      <= 1'b1;
            src_q          <= shadow;
          end
        end
        S_RX_PAD: begin
          if (!dv) begin
            o_rec_pkt_done <= 1'b1;
            o_rec_err      <= CHECK_CRC & fcs_bad;
            src_q          <= shadow;
          end
        end
        default: ;
      endcase
    end
  end

  assign o_src_mac  = src_q.mac;
  assign o_src_ip   = src_q.ip;
  assign o_src_port = src_q.port;

endmodule

// File: tb/tb_udp_rx_word.sv
// Randomised frame bench for udp_rx_word with a byte-level reference model.
module tb_udp_rx_word;

  localparam logic [47:0] BOARD_MAC  = 48'h001122334455;
  localparam logic [31:0] BOARD_IP   = {8'd192, 8'd168, 8'd1, 8'd10};
  localparam logic [15:0] BOARD_PORT = 16'd1010;

  logic        clk = 1'b0;
  logic        rstn;
  logic        dv;
  logic [7:0]  rxd;

  logic        word_en, pkt_done, err;
  logic [31:0] word;
  logic [15:0] byte_num;
  logic [47:0] src_mac;
  logic [31:0] src_ip;
  logic [15:0] src_port;

  logic        word_en_n, pkt_done_n, err_n;
  logic [31:0] word_n;
  logic [15:0] byte_num_n;
  logic [47:0] src_mac_n;
  logic [31:0] src_ip_n;
  logic [15:0] src_port_n;

  always #4 clk = ~clk;

  udp_rx_word dut (
    .i_gmii_rx_clk (clk), .i_sys_rstn (rstn), .i_gmii_rx_dv (dv), .i_gmii_rx_data (rxd),
    .o_rec_word_en (word_en), .o_rec_word (word), .o_rec_byte_num (byte_num),
    .o_rec_pkt_done (pkt_done), .o_rec_err (err),
    .o_src_mac (src_mac), .o_src_ip (src_ip), .o_src_port (src_port)
  );

  udp_rx_word #(.CHECK_CRC(1'b0)) dut_nc (
    .i_gmii_rx_clk (clk), .i_sys_rstn (rstn), .i_gmii_rx_dv (dv), .i_gmii_rx_data (rxd),
    .o_rec_word_en (word_en_n), .o_rec_word (word_n), .o_rec_byte_num (byte_num_n),
    .o_rec_pkt_done (pkt_done_n), .o_rec_err (err_n),
    .o_src_mac (src_mac_n), .o_src_ip (src_ip_n), .o_src_port (src_port_n)
  );

  int total = 0;
  int bad   = 0;

  logic [31:0] got_w[$];
  int          got_done    = 0;
  int          got_done_nc = 0;
  logic        got_err     = 1'b0;
  logic        got_err_nc  = 1'b0;

  logic [7:0]  frm[$];
  logic [7:0]  pay[$];

  logic [47:0] exp_mac  = '0;
  logic [31:0] exp_ip   = '0;
  logic [15:0] exp_port = '0;
  logic [15:0] exp_bn   = '0;

  always @(negedge clk) begin
    if (word_en) got_w.push_back(word);
    if (pkt_done) begin
      got_done = got_done + 1;
      got_err  = err;
    end
    if (pkt_done_n) begin
      got_done_nc = got_done_nc + 1;
      got_err_nc  = err_n;
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic put(input logic [47:0] v, input int n);
    for (int i = n - 1; i >= 0; i--) frm.push_back(v[i*8 +: 8]);
  endtask

  // Ethernet FCS, reflected form, transmitted low byte first.
  function automatic logic [31:0] eth_fcs();
    logic [31:0] r;
    r = '1;
    foreach (frm[i]) begin
      r = r ^ {24'h0, frm[i]};
      for (int b = 0; b < 8; b++) r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
    end
    return ~r;
  endfunction

  task automatic build(input logic [47:0] dmac, input logic [47:0] smac, input logic [31:0] sip,
                       input logic [31:0] dip, input logic [15:0] sport, input logic [15:0] dport);
    logic [31:0] fcs;
    frm.delete();
    put(dmac, 6); put(smac, 6); put(48'h0800, 2);
    put(48'h4500, 2); put(48'(pay.size() + 28), 2); put(48'h0000_4000, 4);
    put(48'h4011, 2); put(48'h0, 2); put(48'(sip), 4); put(48'(dip), 4);
    put(48'(sport), 2); put(48'(dport), 2); put(48'(pay.size() + 8), 2); put(48'h0, 2);
    foreach (pay[i]) frm.push_back(pay[i]);
    while (frm.size() < 60) frm.push_back(8'h00);
    fcs = eth_fcs();
    for (int i = 0; i < 4; i++) frm.push_back(fcs[i*8 +: 8]);
  endtask

  task automatic drive(input logic [7:0] b);
    @(negedge clk);
    dv  = 1'b1;
    rxd = b;
  endtask

  task automatic send(input int n);
    for (int i = 0; i < 8; i++) drive((i == 7) ? 8'hD5 : 8'h55);
    for (int i = 0; i < n; i++) drive(frm[i]);
    @(negedge clk);
    dv  = 1'b0;
    rxd = 8'h00;
    repeat (16) @(negedge clk);
  endtask

  task automatic fill_pay(input int n, input logic [7:0] first, input bit rnd);
    pay.delete();
    for (int i = 0; i < n; i++) pay.push_back(rnd ? 8'($urandom()) : 8'(first + 8'(i)));
  endtask

  task automatic chk_src(input string tag);
    chk({tag, " byte_num"}, 64'(byte_num), 64'(exp_bn));
    chk({tag, " src_mac"},  64'(src_mac),  64'(exp_mac));
    chk({tag, " src_ip"},   64'(src_ip),   64'(exp_ip));
    chk({tag, " src_port"}, 64'(src_port), 64'(exp_port));
  endtask

  // Send one frame built from pay and compare against the model's words/strobes/latches.
  task automatic run_frame(input string tag, input logic [47:0] dmac, input logic [31:0] dip,
                           input logic [15:0] dport, input int trunc, input bit flip);
    logic [47:0] smac;
    logic [31:0] sip, w;
    logic [15:0] sport;
    logic [31:0] expw[$];
    int w0, d0, dn0, nd, n;
    bit acc;
    smac  = 48'({$urandom(), $urandom()});
    sip   = $urandom();
    sport = 16'($urandom());
    build(dmac, smac, sip, dip, sport, dport);
    if (flip) begin
      n = frm.size() - 1 - int'($urandom_range(0, 3));
      frm[n] = frm[n] ^ 8'(8'h01 << $urandom_range(0, 7));
    end
    n   = (trunc > 0) ? 42 + trunc : frm.size();
    w0  = got_w.size();
    d0  = got_done;
    dn0 = got_done_nc;
    send(n);
    acc = (dmac == BOARD_MAC || dmac == 48'hffff_ffff_ffff) && dip == BOARD_IP && dport == BOARD_PORT;
    nd  = !acc ? 0 : ((trunc > 0) ? trunc : pay.size());
    for (int i = 0; i < nd; i += 4) begin
      w = '0;
      for (int k = 0; k < 4; k++) w = {w[23:0], (i + k < nd) ? pay[i+k] : 8'h00};
      expw.push_back(w);
    end
    chk({tag, " nwords"}, 64'(got_w.size() - w0), 64'(expw.size()));
    for (int i = 0; i < expw.size() && w0 + i < got_w.size(); i++)
      chk({tag, " word"}, 64'(got_w[w0+i]), 64'(expw[i]));
    chk({tag, " done"},    64'(got_done - d0),     64'(acc));
    chk({tag, " done_nc"}, 64'(got_done_nc - dn0), 64'(acc));
    if (acc) begin
      chk({tag, " err"},    64'(got_err),    64'(trunc > 0 || flip));
      chk({tag, " err_nc"}, 64'(got_err_nc), 64'(trunc > 0));
      exp_mac  = smac;
      exp_ip   = sip;
      exp_port = sport;
      exp_bn   = 16'(pay.size());
    end
    chk_src(tag);
  endtask

  initial begin
    int w0, d0, kind, plen, tr;
    logic [47:0] dm;
    logic [31:0] di;
    logic [15:0] dp;
    rstn = 1'b1;
    dv   = 1'b0;
    rxd  = 8'h00;
    #2 rstn = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst word_en",  64'(word_en),  64'(0));
    chk("rst word",     64'(word),     64'(0));
    chk("rst pkt_done", 64'(pkt_done), 64'(0));
    chk("rst err",      64'(err),      64'(0));
    chk_src("rst");
    rstn = 1'b1;
    repeat (3) @(negedge clk);

    fill_pay(8, 8'h01, 1'b0);
    w0 = got_w.size();
    run_frame("pay8", BOARD_MAC, BOARD_IP, BOARD_PORT, 0, 1'b0);
    if (got_w.size() >= w0 + 2) begin
      chk("pay8 w0 const", 64'(got_w[w0]),   64'h01020304);
      chk("pay8 w1 const", 64'(got_w[w0+1]), 64'h05060708);
    end
    fill_pay(5, 8'h0A, 1'b0);
    run_frame("pay5", BOARD_MAC, BOARD_IP, BOARD_PORT, 0, 1'b0);
    fill_pay(8, 8'h01, 1'b0);
    run_frame("port1011", BOARD_MAC, BOARD_IP, 16'd1011, 0, 1'b0);
    run_frame("ip11", BOARD_MAC, {8'd192, 8'd168, 8'd1, 8'd11}, BOARD_PORT, 0, 1'b0);
    pay.delete();
    pay.push_back(8'hDE); pay.push_back(8'hAD); pay.push_back(8'hBE); pay.push_back(8'hEF);
    run_frame("bcast", 48'hffff_ffff_ffff, BOARD_IP, BOARD_PORT, 0, 1'b0);
    fill_pay(12, 8'h00, 1'b1);
    run_frame("fcsflip", BOARD_MAC, BOARD_IP, BOARD_PORT, 0, 1'b1);
    fill_pay(10, 8'h00, 1'b1);
    run_frame("trunc6", BOARD_MAC, BOARD_IP, BOARD_PORT, 6, 1'b0);
    fill_pay(0, 8'h00, 1'b1);
    run_frame("empty", BOARD_MAC, BOARD_IP, BOARD_PORT, 0, 1'b0);

    // Reset mid-payload, released while dv is still high.
    fill_pay(20, 8'h00, 1'b1);
    build(BOARD_MAC, 48'h0a0b0c0d0e0f, 32'h0a000001, BOARD_IP, 16'd5000, BOARD_PORT);
    w0 = got_w.size();
    d0 = got_done;
    for (int i = 0; i < 8; i++) drive((i == 7) ? 8'hD5 : 8'h55);
    for (int i = 0; i < frm.size(); i++) begin
      drive(frm[i]);
      if (i == 44) rstn = 1'b0;
      if (i == 47) begin
        exp_mac = '0; exp_ip = '0; exp_port = '0; exp_bn = '0;
        chk("inrst word", 64'(word), 64'(0));
        chk("inrst err",  64'(err),  64'(0));
        chk_src("inrst");
        w0   = got_w.size();
        d0   = got_done;
        rstn = 1'b1;
      end
    end
    @(negedge clk);
    dv = 1'b0;
    repeat (16) @(negedge clk);
    chk("postrst nwords", 64'(got_w.size() - w0), 64'(0));
    chk("postrst done",   64'(got_done - d0),     64'(0));
    fill_pay(9, 8'h00, 1'b1);
    run_frame("afterrst", BOARD_MAC, BOARD_IP, BOARD_PORT, 0, 1'b0);

    for (int f = 0; f < 24; f++) begin
      kind = int'($urandom_range(0, 9));
      plen = int'($urandom_range(0, 30));
      fill_pay(plen, 8'h00, 1'b1);
      dm = BOARD_MAC; di = BOARD_IP; dp = BOARD_PORT; tr = 0;
      case (kind)
        0: dp = 16'(BOARD_PORT + 16'd1 + 16'($urandom_range(0, 100)));
        1: di = BOARD_IP ^ 32'(1 << $urandom_range(0, 31));
        2: dm = BOARD_MAC ^ 48'h010000000000;
        3: dm = 48'hffff_ffff_ffff;
        5: if (plen > 1) tr = int'($urandom_range(1, plen - 1));
        default: ;
      endcase
      run_frame($sformatf("rnd%0d", f), dm, di, dp, tr, kind == 4);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
